misc_csr: RTL and testbench
===========================

# misc_csr

Registered, parametrised successor to the fully combinational misc execution unit. Executes JALR, LUI and SYSTEM (ECALL/EBREAK/MRET) as before, adds Zicsr (CSRRW/CSRRS/CSRRC and immediate forms) over a machine-mode CSR file with a free-running cycle counter, and holds results in a one-entry output stage with a valid/ready handshake. Sits in the execute stage between the issue/decode decoupled channel and writeback/commit. Trap entry and MRET commit are driven back in from the commit stage.

## Interface
- XLEN, 32: datapath width, 32 or 64.
- RESET_MTVEC, 0: reset value of mtvec.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- decoded  decoupled.in  -  decoded instruction (op, rd, rs1, rs1_val, imm, pc, funct3); ready driven by this block.
- result  decoupled.out  -  exec_result payload (rd_idx, rd_val, br_valid, br_target, ex_valid, ex, ret_valid).
- flush  in  1  kill the held result without committing its CSR write.
- trap_valid  in  1  commit takes a trap this cycle.
- trap_cause  in  XLEN  value for mcause.
- trap_pc  in  XLEN  value for mepc.
- trap_tval  in  XLEN  value for mtval.
- mret_commit  in  1  commit retires MRET this cycle.
- mtvec_o, mepc_o  out  XLEN  current mtvec / mepc.
- mie_o  out  1  mstatus.MIE.

## Operation
- JALR: br_valid=1, br_target=rs1_val+imm with bit 0 cleared, rd_val=pc+4. LUI: br_valid=0, rd_val=imm.
- SYSTEM with funct3=0, by imm[4:0]: 0 -> ECALL (ex EX_M_ECALL); 1 -> EBREAK (EX_BREAKPOINT); 2 -> MRET (ret_valid=1, legal only if imm[11:5]=7'b0011000). ECALL/EBREAK need imm[11:5]=0. Any other encoding -> EX_ILLEGAL_INSTR.
- CSR ops (funct3 1/2/3 = RW/RS/RC; 5/6/7 = immediate forms, source = zero-extended rs1 index): csr addr = imm[11:0]. rd_val = old CSR value. New value: RW src; RS old|src; RC old&~src. RS/RC with source 0 perform no write. RW performs its write even when rd=0.
- Implemented CSRs: mstatus 0x300 (only MIE bit3 and MPIE bit7 writable, other bits read 0), mtvec 0x305 (bits[1:0] read 0), mscratch 0x340, mepc 0x341 (bit0 reads 0), mcause 0x342, mtval 0x343, mcycle 0xB00, mcycleh 0xB80 (XLEN=32 only). Any other address, or a write to a read-only address (bits[11:10]=2'b11), -> EX_ILLEGAL_INSTR with no write.
- Each CSR op is evaluated at accept. CSR read value is sampled at accept. The write is held in the output stage and applied only on the result handshake (valid&&ready&&!flush).
- mcycle is 64 bits and increments every cycle. It wraps from all-ones to 0. A CSR write to mcycle (or mcycleh) loads the written half. The counter does not increment in the cycle of that write.
- Trap (trap_valid): mepc<=trap_pc, mcause<=trap_cause, mtval<=trap_tval, MPIE<=MIE, MIE<=0, and the held result is dropped.
- mret_commit: MIE<=MPIE, MPIE<=1.
- Priority: rst > trap_valid > flush > CSR write from handshake. mret_commit in the same cycle as trap_valid is ignored.

## Timing
- Latency: 1 cycle (accept in cycle N -> result.valid in N+1).
- Reset values: result.valid=0, mstatus=0, mtvec=RESET_MTVEC, mscratch/mepc/mcause/mtval=0, mcycle=0, mie_o=0.
- decoded.ready = !out_valid || (result.ready && !out_is_csr). Full throughput for non-CSR ops.
- A held CSR op forces one bubble, so a following CSR read always sees the committed write.
- While result.valid=1 and result.ready=0, the payload is held stable.
- flush or trap clears out_valid next cycle. decoded.ready stays 0 in the flush/trap cycle.
- Outputs mtvec_o, mepc_o and mie_o reflect register state (the new value appears the cycle after the write).

## Test plan
- Reset, then JALR with rs1_val=0x1001, imm=4, pc=0x100 -> next cycle result.valid=1, br_target=0x1004, rd_val=0x104.
- CSRRW mscratch with rs1_val=0xDEADBEEF, immediately followed by CSRRS mscratch with rs1=x0, result.ready=1 -> second op accepted one cycle late (bubble), reads 0xDEADBEEF.
- CSRRW to mtvec held with result.ready=0, then flush -> mtvec unchanged, result.valid=0 next cycle.
- trap_valid with cause=2, pc=0x80, MIE=1 -> mepc=0x80, mcause=2, MIE=0, MPIE=1; then mret_commit -> MIE=1, MPIE=1.
- Write 0xFFFFFFFF to mcycle and mcycleh (XLEN=32), then idle -> counter reads 0 one cycle after the second write commits.
- CSRRW to 0xC00 (read-only) and to unimplemented 0x7C0 -> ex_valid=1, ex=EX_ILLEGAL_INSTR, no state change.

Source files
------------

// File: rtl/misc_csr.sv
// Execute-stage misc unit: JALR/LUI/SYSTEM plus Zicsr over a machine-mode CSR file,
// with a one-entry valid/ready output stage that holds each CSR write until the result is committed.
module misc_csr #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_decoded_valid,
  output logic            o_decoded_ready,
  input  logic [1:0]      i_decoded_op,
  input  logic [4:0]      i_decoded_rd,
  input  logic [4:0]      i_decoded_rs1,
  input  logic [XLEN-1:0] i_decoded_rs1_val,
  input  logic [XLEN-1:0] i_decoded_imm,
  input  logic [XLEN-1:0] i_decoded_pc,
  input  logic [2:0]      i_decoded_funct3,
  output logic            o_result_valid,
  input  logic            i_result_ready,
  output logic [4:0]      o_result_rd_idx,
  output logic [XLEN-1:0] o_result_rd_val,
  output logic            o_result_br_valid,
  output logic [XLEN-1:0] o_result_br_target,
  output logic            o_result_ex_valid,
  output logic [3:0]      o_result_ex,
  output logic            o_result_ret_valid,
  input  logic            i_flush,
  input  logic            i_trap_valid,
  input  logic [XLEN-1:0] i_trap_cause,
  input  logic [XLEN-1:0] i_trap_pc,
  input  logic [XLEN-1:0] i_trap_tval,
  input  logic            i_mret_commit,
  output logic [XLEN-1:0] o_mtvec,
  output logic [XLEN-1:0] o_mepc,
  output logic            o_mie
);
  localparam logic [1:0] OP_JALR = 2'd0;
  localparam logic [1:0] OP_LUI  = 2'd1;
  localparam logic [1:0] OP_SYS  = 2'd2;
  localparam logic [3:0] EX_ILLEGAL_INSTR = 4'd2;
  localparam logic [3:0] EX_BREAKPOINT    = 4'd3;
  localparam logic [3:0] EX_M_ECALL       = 4'd11;

  typedef struct packed {
    logic [4:0]      rd_idx;
    logic [XLEN-1:0] rd_val;
    logic            br_valid;
    logic [XLEN-1:0] br_target;
    logic            ex_valid;
    logic [3:0]      ex;
    logic            ret_valid;
    logic            is_csr;
    logic            csr_we;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
  } res_t;

  logic            r_valid;
  res_t            r_res, w_res;
  logic            r_mie, r_mpie;
  logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic [63:0]     r_mcycle, w_mcycle_nxt, w_wd64;
  logic [XLEN-1:0] w_src, w_rdata, w_wdata, w_mstatus;
  logic [11:0]     w_addr;
  logic            w_hit, w_wr_req, w_accept, w_commit;

  assign w_mstatus = XLEN'({r_mpie, 3'b000, r_mie, 3'b000});
  assign o_mtvec   = {r_mtvec[XLEN-1:2], 2'b00};
  assign o_mepc    = {r_mepc[XLEN-1:1], 1'b0};
  assign o_mie     = r_mie;

  // A held CSR op blocks issue so the next CSR read sees its committed write.
  assign o_decoded_ready = (!r_valid || (i_result_ready && !r_res.is_csr)) && !i_flush && !i_trap_valid;
  assign w_accept = i_decoded_valid && o_decoded_ready;
  assign w_commit = r_valid && i_result_ready && !i_flush && !i_trap_valid;

  assign o_result_valid     = r_valid;
  assign o_result_rd_idx    = r_res.rd_idx;
  assign o_result_rd_val    = r_res.rd_val;
  assign o_result_br_valid  = r_res.br_valid;
  assign o_result_br_target = r_res.br_target;
  assign o_result_ex_valid  = r_res.ex_valid;
  assign o_result_ex        = r_res.ex;
  assign o_result_ret_valid = r_res.ret_valid;

  always_comb begin
    w_src   = i_decoded_funct3[2] ? XLEN'(i_decoded_rs1) : i_decoded_rs1_val;
    w_addr  = i_decoded_imm[11:0];
    w_hit   = 1'b1;
    w_rdata = '0;
    case (w_addr)
      12'h300: w_rdata = w_mstatus;
      12'h305: w_rdata = o_mtvec;
      12'h340: w_rdata = r_mscratch;
      12'h341: w_rdata = o_mepc;
      12'h342: w_rdata = r_mcause;
      12'h343: w_rdata = r_mtval;
      12'hB00: w_rdata = r_mcycle[XLEN-1:0];
      12'hB80: begin
        w_rdata = XLEN'(r_mcycle[63:32]);
        w_hit   = (XLEN == 32);
      end
      default: w_hit = 1'b0;
    endcase
    w_wr_req = (i_decoded_funct3[1:0] == 2'b01) || (w_src != '0);
    case (i_decoded_funct3[1:0])
      2'b01:   w_wdata = w_src;
      2'b10:   w_wdata = w_rdata | w_src;
      default: w_wdata = w_rdata & ~w_src;
    endcase
  end

  always_comb begin
    w_res        = '0;
    w_res.rd_idx = i_decoded_rd;
    case (i_decoded_op)
      OP_JALR: begin
        w_res.rd_val    = i_decoded_pc + XLEN'(4);
        w_res.br_valid  = 1'b1;
        w_res.br_target = (i_decoded_rs1_val + i_decoded_imm) & ~XLEN'(1);
      end
      OP_LUI: w_res.rd_val = i_decoded_imm;
      OP_SYS: begin
        w_res.ex_valid = 1'b1;
        w_res.ex       = EX_ILLEGAL_INSTR;
        if (i_decoded_funct3 == 3'd0) begin
          if (i_decoded_imm[4:0] == 5'd0 && i_decoded_imm[11:5] == 7'd0) begin
            w_res.ex = EX_M_ECALL;
          end else if (i_decoded_imm[4:0] == 5'd1 && i_decoded_imm[11:5] == 7'd0) begin
            w_res.ex = EX_BREAKPOINT;
          end else if (i_decoded_imm[4:0] == 5'd2 && i_decoded_imm[11:5] == 7'b0011000) begin
            w_res.ex_valid  = 1'b0;
            w_res.ex        = '0;
            w_res.ret_valid = 1'b1;
          end
        end else if (i_decoded_funct3 != 3'd4) begin
          w_res.is_csr = 1'b1;
          w_res.rd_val = w_rdata;
          if (w_hit && !(w_wr_req && w_addr[11:10] == 2'b11)) begin
            w_res.ex_valid  = 1'b0;
            w_res.ex        = '0;
            w_res.csr_we    = w_wr_req;
            w_res.csr_addr  = w_addr;
            w_res.csr_wdata = w_wdata;
          end
        end
      end
      default: begin
        w_res.ex_valid = 1'b1;
        w_res.ex       = EX_ILLEGAL_INSTR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_res   <= '0;
    end else if (i_trap_valid || i_flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_res   <= w_res;
    end else if (w_commit) begin
      r_valid <= 1'b0;
    end
  end

  // A committed write to either half replaces the increment for that cycle.
  always_comb begin
    w_wd64       = 64'(r_res.csr_wdata);
    w_mcycle_nxt = r_mcycle + 64'd1;
    if (w_commit && r_res.csr_we && r_res.csr_addr == 12'hB00) begin
      w_mcycle_nxt = (XLEN == 32) ? {r_mcycle[63:32], w_wd64[31:0]} : w_wd64;
    end else if (w_commit && r_res.csr_we && r_res.csr_addr == 12'hB80) begin
      w_mcycle_nxt = {w_wd64[31:0], r_mcycle[31:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_mcycle <= '0;
    else     r_mcycle <= w_mcycle_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtvec    <= RESET_MTVEC;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
    end else if (i_trap_valid) begin
      r_mepc   <= i_trap_pc;
      r_mcause <= i_trap_cause;
      r_mtval  <= i_trap_tval;
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
    end else begin
      if (w_commit && r_res.csr_we) begin
        case (r_res.csr_addr)
          12'h300: begin
            r_mie  <= r_res.csr_wdata[3];
            r_mpie <= r_res.csr_wdata[7];
          end
          12'h305: r_mtvec    <= r_res.csr_wdata;
          12'h340: r_mscratch <= r_res.csr_wdata;
          12'h341: r_mepc     <= r_res.csr_wdata;
          12'h342: r_mcause   <= r_res.csr_wdata;
          12'h343: r_mtval    <= r_res.csr_wdata;
          default: ;
        endcase
      end
      if (i_mret_commit) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_misc_csr.sv
// Directed bench for misc_csr: one task per scenario, hand-computed expectations.
module tb_misc_csr;
  localparam logic [1:0] OP_JALR = 2'd0;
  localparam logic [1:0] OP_LUI  = 2'd1;
  localparam logic [1:0] OP_SYS  = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_decoded_valid, o_decoded_ready;
  logic [1:0]  i_decoded_op;
  logic [4:0]  i_decoded_rd, i_decoded_rs1;
  logic [31:0] i_decoded_rs1_val, i_decoded_imm, i_decoded_pc;
  logic [2:0]  i_decoded_funct3;
  logic        o_result_valid, i_result_ready;
  logic [4:0]  o_result_rd_idx;
  logic [31:0] o_result_rd_val, o_result_br_target;
  logic        o_result_br_valid, o_result_ex_valid, o_result_ret_valid;
  logic [3:0]  o_result_ex;
  logic        i_flush, i_trap_valid, i_mret_commit;
  logic [31:0] i_trap_cause, i_trap_pc, i_trap_tval;
  logic [31:0] o_mtvec, o_mepc;
  logic        o_mie;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  misc_csr #(.XLEN(32), .RESET_MTVEC(32'h100)) dut (
    .clk(clk), .rst(rst),
    .i_decoded_valid(i_decoded_valid), .o_decoded_ready(o_decoded_ready),
    .i_decoded_op(i_decoded_op), .i_decoded_rd(i_decoded_rd), .i_decoded_rs1(i_decoded_rs1),
    .i_decoded_rs1_val(i_decoded_rs1_val), .i_decoded_imm(i_decoded_imm),
    .i_decoded_pc(i_decoded_pc), .i_decoded_funct3(i_decoded_funct3),
    .o_result_valid(o_result_valid), .i_result_ready(i_result_ready),
    .o_result_rd_idx(o_result_rd_idx), .o_result_rd_val(o_result_rd_val),
    .o_result_br_valid(o_result_br_valid), .o_result_br_target(o_result_br_target),
    .o_result_ex_valid(o_result_ex_valid), .o_result_ex(o_result_ex),
    .o_result_ret_valid(o_result_ret_valid),
    .i_flush(i_flush), .i_trap_valid(i_trap_valid), .i_trap_cause(i_trap_cause),
    .i_trap_pc(i_trap_pc), .i_trap_tval(i_trap_tval), .i_mret_commit(i_mret_commit),
    .o_mtvec(o_mtvec), .o_mepc(o_mepc), .o_mie(o_mie)
  );

  // Present one op, wait (bounded) for acceptance, return the stall count; returns #1 after the accept edge.
  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [31:0] rs1v, input logic [31:0] imm,
                      input logic [31:0] pc, output int waited);
    int n;
    i_decoded_op = op; i_decoded_funct3 = f3; i_decoded_rd = rd; i_decoded_rs1 = rs1;
    i_decoded_rs1_val = rs1v; i_decoded_imm = imm; i_decoded_pc = pc;
    i_decoded_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o_decoded_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL accept_timeout got=stalled exp=accepted within 20 cycles");
    end
    @(posedge clk);
    #1;
    i_decoded_valid = 1'b0;
    waited = n;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_decoded_valid = 1'b0; i_result_ready = 1'b0; i_flush = 1'b0;
    i_trap_valid = 1'b0; i_mret_commit = 1'b0; i_trap_cause = '0; i_trap_pc = '0; i_trap_tval = '0;
    i_decoded_op = '0; i_decoded_rd = '0; i_decoded_rs1 = '0; i_decoded_rs1_val = '0;
    i_decoded_imm = '0; i_decoded_pc = '0; i_decoded_funct3 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_result_valid); end
    checks++; if (o_mtvec !== 32'h100) begin errors++; $display("FAIL reset_mtvec got=%h exp=00000100", o_mtvec); end
    checks++; if (o_mepc !== 32'h0) begin errors++; $display("FAIL reset_mepc got=%h exp=0", o_mepc); end
    checks++; if (o_mie !== 1'b0) begin errors++; $display("FAIL reset_mie got=%b exp=0", o_mie); end
    checks++; if (o_decoded_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_decoded_ready); end
    rst = 1'b0;
  endtask

  task automatic test_jalr();
    int w;
    i_result_ready = 1'b1;
    send(OP_JALR, 3'd0, 5'd1, 5'd3, 32'h1001, 32'd4, 32'h100, w);
    checks++; if (o_result_valid !== 1'b1) begin errors++; $display("FAIL jalr_valid got=%b exp=1", o_result_valid); end
    checks++; if (o_result_br_valid !== 1'b1) begin errors++; $display("FAIL jalr_br_valid got=%b exp=1", o_result_br_valid); end
    checks++; if (o_result_br_target !== 32'h1004) begin errors++; $display("FAIL jalr_target got=%h exp=00001004", o_result_br_target); end
    checks++; if (o_result_rd_val !== 32'h104) begin errors++; $display("FAIL jalr_rd_val got=%h exp=00000104", o_result_rd_val); end
    checks++; if (o_result_rd_idx !== 5'd1) begin errors++; $display("FAIL jalr_rd_idx got=%0d exp=1", o_result_rd_idx); end
    checks++; if (o_result_ex_valid !== 1'b0) begin errors++; $display("FAIL jalr_ex_valid got=%b exp=0", o_result_ex_valid); end
  endtask

  task automatic test_back_to_back();
    int w;
    send(OP_LUI, 3'd0, 5'd2, 5'd0, 32'h0, 32'h12345000, 32'h0, w);
    checks++; if (w !== 0) begin errors++; $display("FAIL b2b_lui_stall got=%0d exp=0", w); end
    checks++; if (o_result_rd_val !== 32'h12345000 || o_result_br_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_lui got=%h/%b exp=12345000/0", o_result_rd_val, o_result_br_valid); end
    send(OP_JALR, 3'd0, 5'd4, 5'd5, 32'h2000, 32'hFFFFFFF8, 32'h200, w);
    checks++; if (w !== 0) begin errors++; $display("FAIL b2b_jalr_stall got=%0d exp=0", w); end
    checks++; if (o_result_br_target !== 32'h1FF8 || o_result_rd_val !== 32'h204) begin
      errors++; $display("FAIL b2b_jalr got=%h/%h exp=00001ff8/00000204", o_result_br_target, o_result_rd_val); end
    @(posedge clk); #1;
    checks++; if (o_result_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", o_result_valid); end
  endtask

  task automatic test_csr_bubble();
    int w;
    send(OP_SYS, 3'd1, 5'd6, 5'd7, 32'hDEADBEEF, 32'h340, 32'h0, w);
    checks++; if (o_result_rd_val !== 32'h0) begin errors++; $display("FAIL csrrw_old got=%h exp=0", o_result_rd_val); end
    send(OP_SYS, 3'd2, 5'd6, 5'd0, 32'h0, 32'h340, 32'h0, w);
    checks++; if (w !== 1) begin errors++; $display("FAIL csr_bubble got=%0d exp=1", w); end
    checks++; if (o_result_rd_val !== 32'hDEADBEEF) begin errors++; $display("FAIL csrrs_read got=%h exp=deadbeef", o_result_rd_val); end
    send(OP_SYS, 3'd3, 5'd6, 5'd9, 32'hFFFF0000, 32'h340, 32'h0, w);
    checks++; if (o_result_rd_val !== 32'hDEADBEEF) begin errors++; $display("FAIL csrrc_old got=%h exp=deadbeef", o_result_rd_val); end
    send(OP_SYS, 3'd2, 5'd6, 5'd0, 32'h0, 32'h340, 32'h0, w);
    checks++; if (o_result_rd_val !== 32'h0000BEEF) begin errors++; $display("FAIL csrrc_result got=%h exp=0000beef", o_result_rd_val); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    int w;
    send(OP_SYS, 3'd1, 5'd0, 5'd1, 32'h2003, 32'h305, 32'h0, w);
    checks++; if (o_result_rd_val !== 32'h100) begin errors++; $display("FAIL mtvec_old got=%h exp=00000100", o_result_rd_val); end
    @(posedge clk); #1;
    checks++; if (o_mtvec !== 32'h2000) begin errors++; $display("FAIL mtvec_write got=%h exp=00002000", o_mtvec); end
    i_result_ready = 1'b0;
    send(OP_SYS, 3'd1, 5'd0, 5'd1, 32'h3000, 32'h305, 32'h0, w);
    @(posedge clk); #1;
    checks++; if (o_result_valid !== 1'b1 || o_result_rd_val !== 32'h2000) begin
      errors++; $display("FAIL hold_stable got=%b/%h exp=1/00002000", o_result_valid, o_result_rd_val); end
    checks++; if (o_mtvec !== 32'h2000) begin errors++; $display("FAIL hold_no_write got=%h exp=00002000", o_mtvec); end
    i_flush = 1'b1;
    i_result_ready = 1'b1;
    @(negedge clk);
    checks++; if (o_decoded_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", o_decoded_ready); end
    @(posedge clk); #1;
    i_flush = 1'b0;
    checks++; if (o_result_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", o_result_valid); end
    @(posedge clk); #1;
    checks++; if (o_mtvec !== 32'h2000) begin errors++; $display("FAIL flush_mtvec got=%h exp=00002000", o_mtvec); end
  endtask

  task automatic test_trap();
    int w;
    send(OP_SYS, 3'd6, 5'd0, 5'd8, 32'h0, 32'h300, 32'h0, w);
    checks++; if (o_result_rd_val !== 32'h0) begin errors++; $display("FAIL csrrsi_old got=%h exp=0", o_result_rd_val); end
    @(posedge clk); #1;
    checks++; if (o_mie !== 1'b1) begin errors++; $display("FAIL mie_set got=%b exp=1", o_mie); end
    i_result_ready = 1'b0;
    send(OP_LUI, 3'd0, 5'd3, 5'd0, 32'h0, 32'h7000, 32'h0, w);
    i_trap_valid = 1'b1; i_trap_cause = 32'd2; i_trap_pc = 32'h80; i_trap_tval = 32'h33;
    @(posedge clk); #1;
    i_trap_valid = 1'b0;
    checks++; if (o_result_valid !== 1'b0) begin errors++; $display("FAIL trap_drop got=%b exp=0", o_result_valid); end
    checks++; if (o_mepc !== 32'h80) begin errors++; $display("FAIL trap_mepc got=%h exp=00000080", o_mepc); end
    checks++; if (o_mie !== 1'b0) begin errors++; $display("FAIL trap_mie got=%b exp=0", o_mie); end
    i_result_ready = 1'b1;
    send(OP_SYS, 3'd2, 5'd1, 5'd0, 32'h0, 32'h300, 32'h0, w);
    checks++; if (o_result_rd_val !== 32'h80) begin errors++; $display("FAIL trap_mstatus got=%h exp=00000080", o_result_rd_val); end
    send(OP_SYS, 3'd2, 5'd1, 5'd0, 32'h0, 32'h342, 32'h0, w);
    checks++; if (o_result_rd_val !== 32'd2) begin errors++; $display("FAIL trap_mcause got=%h exp=00000002", o_result_rd_val); end
    send(OP_SYS, 3'd2, 5'd1, 5'd0, 32'h0, 32'h343, 32'h0, w);
    checks++; if (o_result_rd_val !== 32'h33) begin errors++; $display("FAIL trap_mtval got=%h exp=00000033", o_result_rd_val); end
    @(posedge clk); #1;
    i_mret_commit = 1'b1;
    @(posedge clk); #1;
    i_mret_commit = 1'b0;
    checks++; if (o_mie !== 1'b1) begin errors++; $display("FAIL mret_mie got=%b exp=1", o_mie); end
    send(OP_SYS, 3'd2, 5'd1, 5'd0, 32'h0, 32'h300, 32'h0, w);
    checks++; if (o_result_rd_val !== 32'h88) begin errors++; $display("FAIL mret_mstatus got=%h exp=00000088", o_result_rd_val); end
    @(posedge clk); #1;
  endtask

  task automatic test_mcycle();
    int w;
    send(OP_SYS, 3'd1, 5'd0, 5'd1, 32'hFFFFFFFF, 32'hB80, 32'h0, w);
    send(OP_SYS, 3'd1, 5'd0, 5'd1, 32'hFFFFFFFF, 32'hB00, 32'h0, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    send(OP_SYS, 3'd2, 5'd1, 5'd0, 32'h0, 32'hB00, 32'h0, w);
    checks++; if (o_result_rd_val !== 32'h0) begin errors++; $display("FAIL mcycle_wrap_lo got=%h exp=0", o_result_rd_val); end
    send(OP_SYS, 3'd2, 5'd1, 5'd0, 32'h0, 32'hB80, 32'h0, w);
    checks++; if (o_result_rd_val !== 32'h0) begin errors++; $display("FAIL mcycle_wrap_hi got=%h exp=0", o_result_rd_val); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    int w;
    send(OP_SYS, 3'd1, 5'd1, 5'd1, 32'h5, 32'hC00, 32'h0, w);
    checks++; if (o_result_ex_valid !== 1'b1 || o_result_ex !== 4'd2) begin
      errors++; $display("FAIL ill_ro got=%b/%0d exp=1/2", o_result_ex_valid, o_result_ex); end
    send(OP_SYS, 3'd1, 5'd1, 5'd1, 32'h5, 32'h7C0, 32'h0, w);
    checks++; if (o_result_ex_valid !== 1'b1 || o_result_ex !== 4'd2) begin
      errors++; $display("FAIL ill_unimpl got=%b/%0d exp=1/2", o_result_ex_valid, o_result_ex); end
    send(OP_SYS, 3'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, w);
    checks++; if (o_result_ex_valid !== 1'b1 || o_result_ex !== 4'd11) begin
      errors++; $display("FAIL ecall got=%b/%0d exp=1/11", o_result_ex_valid, o_result_ex); end
    send(OP_SYS, 3'd0, 5'd0, 5'd0, 32'h0, 32'h1, 32'h0, w);
    checks++; if (o_result_ex_valid !== 1'b1 || o_result_ex !== 4'd3) begin
      errors++; $display("FAIL ebreak got=%b/%0d exp=1/3", o_result_ex_valid, o_result_ex); end
    send(OP_SYS, 3'd0, 5'd0, 5'd0, 32'h0, 32'h302, 32'h0, w);
    checks++; if (o_result_ret_valid !== 1'b1 || o_result_ex_valid !== 1'b0) begin
      errors++; $display("FAIL mret got=%b/%b exp=1/0", o_result_ret_valid, o_result_ex_valid); end
    send(OP_SYS, 3'd0, 5'd0, 5'd0, 32'h0, 32'h102, 32'h0, w);
    checks++; if (o_result_ex_valid !== 1'b1 || o_result_ex !== 4'd2 || o_result_ret_valid !== 1'b0) begin
      errors++; $display("FAIL mret_bad got=%b/%0d/%b exp=1/2/0", o_result_ex_valid, o_result_ex, o_result_ret_valid); end
    @(posedge clk); #1;
    checks++; if (o_mtvec !== 32'h2000 || o_mepc !== 32'h80) begin
      errors++; $display("FAIL ill_no_change got=%h/%h exp=00002000/00000080", o_mtvec, o_mepc); end
  endtask

  initial begin
    test_reset();
    test_jalr();
    test_back_to_back();
    test_csr_bubble();
    test_flush();
    test_trap();
    test_mcycle();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
